// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one read or write transaction on the RTC chip's
// multiplexed 8-bit address/data bus. It has seven timed bus phases of
// PHASE_CYCLES clocks each, followed by a one-clock DONE.
// All bus controls are registered. Each register is loaded with the value
// for the state being entered, so the pins change on the same edge as the state.
module rtc_bus_sequencer #(
    parameter int DATA_W       = 8,
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_oe,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              ad_n
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_SETUP,
        S_ADDR_STROBE,
        S_ADDR_HOLD,
        S_TURN,
        S_DATA_SETUP,
        S_DATA_STROBE,
        S_DATA_HOLD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic ad_n;
        logic oe;
    } ctl_t;

    localparam ctl_t            CTL_IDLE = 5'b11110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    ctl_t                ctl;
    logic                rw_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    // Phase order of a transaction; IDLE and DONE are sequenced explicitly.
    function automatic state_t next_phase(input state_t s);
        case (s)
            S_ADDR_SETUP:  return S_ADDR_STROBE;
            S_ADDR_STROBE: return S_ADDR_HOLD;
            S_ADDR_HOLD:   return S_TURN;
            S_TURN:        return S_DATA_SETUP;
            S_DATA_SETUP:  return S_DATA_STROBE;
            S_DATA_STROBE: return S_DATA_HOLD;
            S_DATA_HOLD:   return S_DONE;
            default:       return S_IDLE;
        endcase
    endfunction

    // Strobe/enable pattern held for the whole of a state. For a read the pad
    // driver is never enabled during the data phases, so rd_n=0 with oe=1
    // cannot occur.
    function automatic ctl_t ctl_of(input state_t s, input logic is_rd);
        ctl_t c;
        c = CTL_IDLE;
        case (s)
            S_ADDR_SETUP, S_ADDR_HOLD: begin
                c.cs_n = 1'b0;
                c.ad_n = 1'b0;
                c.oe   = 1'b1;
            end
            S_ADDR_STROBE: begin
                c.cs_n = 1'b0;
                c.ad_n = 1'b0;
                c.wr_n = 1'b0;
                c.oe   = 1'b1;
            end
            S_DATA_SETUP, S_DATA_HOLD: begin
                c.cs_n = 1'b0;
                c.oe   = ~is_rd;
            end
            S_DATA_STROBE: begin
                c.cs_n = 1'b0;
                c.oe   = ~is_rd;
                c.rd_n = ~is_rd;
                c.wr_n = is_rd;
            end
            default: c = CTL_IDLE;
        endcase
        return c;
    endfunction

    // Pad data for a state: address in the address phases, write data in the
    // data phases of a write, zero whenever the pad is not driven.
    function automatic logic [DATA_W-1:0] dout_of(input state_t s, input logic is_rd,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] w);
        case (s)
            S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD:  return a;
            S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD:  return is_rd ? '0 : w;
            default:                                   return '0;
        endcase
    endfunction

    // Request fields are plain data: they are loaded on accept and need no reset.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Transaction FSM with registered bus controls, handshake and read capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ctl      <= CTL_IDLE;
            bus_dout <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ADDR_SETUP;
                        cnt      <= '0;
                        ctl      <= ctl_of(S_ADDR_SETUP, rw);
                        bus_dout <= dout_of(S_ADDR_SETUP, rw, addr, wdata);
                        busy     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    ctl      <= CTL_IDLE;
                    bus_dout <= '0;
                    busy     <= 1'b0;
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        state    <= next_phase(state);
                        ctl      <= ctl_of(next_phase(state), rw_q);
                        bus_dout <= dout_of(next_phase(state), rw_q, addr_q, wdata_q);
                        if (next_phase(state) == S_DONE) begin
                            done <= 1'b1;
                        end
                        // Sample the pad on the last clock that rd_n is low.
                        if (state == S_DATA_STROBE && rw_q) begin
                            rdata <= bus_din;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign cs_n   = ctl.cs_n;
    assign rd_n   = ctl.rd_n;
    assign wr_n   = ctl.wr_n;
    assign ad_n   = ctl.ad_n;
    assign bus_oe = ctl.oe;

endmodule
